// File: rtl/pio_seq_pkg.sv
// ============================================================================
// pio_seq_pkg : shared types and constants for the PIO strobe sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package pio_seq_pkg;

   localparam int DATA_W     = 8;
   localparam int STROBE_BIT = DATA_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } seq_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Wide enough to hold the largest (phase length - 1) reload value.
   function automatic int cnt_width(input int s, input int t, input int h);
      return $clog2(max3(s, t, h) + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pio_strobe_sequencer_if.sv
// ============================================================================
// pio_strobe_sequencer_if : requester handshakes and PIO bus outputs
// Optional PIO_SEQ_STATS_EN adds per-requester transfer counters.  Rev 1.0
// ============================================================================
`default_nettype none

interface pio_strobe_sequencer_if #(
   parameter int DATA_W = 8
);

   logic              req0_valid;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic [DATA_W:0]   out_port;
   logic              busy;
   logic              grant_id;
   logic              done;
`ifdef PIO_SEQ_STATS_EN
   logic [15:0]       xfer_cnt0;
   logic [15:0]       xfer_cnt1;

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data,
      input  req0_ready, req1_ready, out_port, busy, grant_id, done,
      input  xfer_cnt0, xfer_cnt1
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data,
      output req0_ready, req1_ready, out_port, busy, grant_id, done,
      output xfer_cnt0, xfer_cnt1
   );
`else
   modport master (
      output req0_valid, req0_data, req1_valid, req1_data,
      input  req0_ready, req1_ready, out_port, busy, grant_id, done
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data,
      output req0_ready, req1_ready, out_port, busy, grant_id, done
   );
`endif

endinterface

`default_nettype wire

// File: rtl/pio_rr_arb2.sv
// ============================================================================
// pio_rr_arb2 : two-way round-robin arbiter, grant is one-hot (zero if idle)
// Rev 1.0
// ============================================================================
`default_nettype none

module pio_rr_arb2 (
   input  logic [1:0] valid,
   input  logic       rr_last,
   output logic [1:0] grant,
   output logic       grant_id
);

   always_comb begin
      grant_id = 1'b0;
      grant    = 2'b00;
      case (valid)
         2'b01:   grant_id = 1'b0;
         2'b10:   grant_id = 1'b1;
         2'b11:   grant_id = ~rr_last;
         default: grant_id = 1'b0;
      endcase
      if (valid != 2'b00) begin
         grant = grant_id ? 2'b10 : 2'b01;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pio_strobe_sequencer.sv
// ============================================================================
// pio_strobe_sequencer : arbitrates two byte sources onto a strobed PIO bus
// with setup/strobe/hold timing; PIO_SEQ_STATS_EN adds transfer counters. Rev 1.0
// ============================================================================
`default_nettype none

module pio_strobe_sequencer
   import pio_seq_pkg::*;
#(
   parameter int DATA_W     = pio_seq_pkg::DATA_W,
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 4,
   parameter int HOLD_CYC   = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   pio_strobe_sequencer_if.slave bus
);

   localparam int CNT_W = cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC);
   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   seq_state_t        state;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] data_q;
   logic              strobe_q;
   logic              busy_q;
   logic              grant_q;
   logic              done_q;
   logic              rr_last;

   logic [1:0]        valid;
   logic [1:0]        grant;
   logic              arb_id;
   logic              accept;
   logic [DATA_W-1:0] accept_data;

   assign valid = {bus.req1_valid, bus.req0_valid};

   pio_rr_arb2 u_arb (
      .valid    (valid),
      .rr_last  (rr_last),
      .grant    (grant),
      .grant_id (arb_id)
   );

   assign accept         = (state == IDLE) && (grant != 2'b00);
   assign bus.req0_ready = (state == IDLE) && grant[0];
   assign bus.req1_ready = (state == IDLE) && grant[1];
   assign accept_data    = arb_id ? bus.req1_data : bus.req0_data;

   // Data stays on the bus through IDLE; only the strobe returns low.
   assign bus.out_port = {strobe_q, data_q};
   assign bus.busy     = busy_q;
   assign bus.grant_id = grant_q;
   assign bus.done     = done_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         count    <= '0;
         data_q   <= '0;
         strobe_q <= 1'b0;
         busy_q   <= 1'b0;
         grant_q  <= 1'b0;
         done_q   <= 1'b0;
         rr_last  <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  data_q  <= accept_data;
                  grant_q <= arb_id;
                  rr_last <= arb_id;
                  busy_q  <= 1'b1;
                  count   <= SETUP_LD;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               if (count == '0) begin
                  strobe_q <= 1'b1;
                  count    <= STROBE_LD;
                  state    <= STROBE;
               end else begin
                  count <= count - CNT_ONE;
               end
            end
            STROBE: begin
               if (count == '0) begin
                  strobe_q <= 1'b0;
                  count    <= HOLD_LD;
                  state    <= HOLD;
               end else begin
                  count <= count - CNT_ONE;
               end
            end
            HOLD: begin
               if (count == '0) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= IDLE;
               end else begin
                  count <= count - CNT_ONE;
               end
            end
            default: begin
               strobe_q <= 1'b0;
               busy_q   <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

`ifdef PIO_SEQ_STATS_EN
   logic [15:0] stat_cnt0;
   logic [15:0] stat_cnt1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_cnt0 <= '0;
         stat_cnt1 <= '0;
      end else if (done_q) begin
         if (!grant_q && (stat_cnt0 != 16'hFFFF)) begin
            stat_cnt0 <= stat_cnt0 + 16'd1;
         end
         if (grant_q && (stat_cnt1 != 16'hFFFF)) begin
            stat_cnt1 <= stat_cnt1 + 16'd1;
         end
      end
   end

   assign bus.xfer_cnt0 = stat_cnt0;
   assign bus.xfer_cnt1 = stat_cnt1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pio_strobe_sequencer.sv
// ============================================================================
// tb_pio_strobe_sequencer : scoreboard bench for pio_strobe_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pio_strobe_sequencer;
   import pio_seq_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   pio_strobe_sequencer_if #(.DATA_W(8)) bus ();
   pio_strobe_sequencer_if #(.DATA_W(8)) busf ();

   pio_strobe_sequencer #(
      .DATA_W(8), .SETUP_CYC(2), .STROBE_CYC(4), .HOLD_CYC(2)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   pio_strobe_sequencer #(
      .DATA_W(8), .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)
   ) dut_fast (
      .clk(clk), .reset_n(reset_n), .bus(busf)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard entries are {grant_id, data}, popped on each strobe rise.
   logic [8:0] exp_q[$];
   int         rise_cyc[$];
   int         cyc = 0;
   int         done_cnt = 0;
   logic       strobe_prev = 1'b0;
   int         high_len = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      logic [8:0] e;
      if (!reset_n) begin
         strobe_prev = 1'b0;
         high_len    = 0;
      end else begin
         if (bus.done) done_cnt++;
         if (bus.out_port[STROBE_BIT] && !strobe_prev) begin
            rise_cyc.push_back(cyc);
            check("sb_nonempty_at_rise", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("sb_data", 32'(bus.out_port[7:0]), 32'(e[7:0]));
               check("sb_grant", 32'(bus.grant_id), 32'(e[8]));
            end
         end
         if (bus.out_port[STROBE_BIT]) begin
            high_len = strobe_prev ? high_len + 1 : 1;
         end else if (strobe_prev) begin
            check("strobe_width", high_len, 32'd4);
            high_len = 0;
         end
         strobe_prev = bus.out_port[STROBE_BIT];
      end
   end

   task automatic do_reset();
      reset_n        = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_out_port", 32'(bus.out_port), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_grant_id", 32'(bus.grant_id), 32'h0);
      check("rst_done", 32'(bus.done), 32'h0);
      exp_q.delete();
      rise_cyc.delete();
      reset_n = 1'b1;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      @(negedge clk);
      while (!bus.done && n < 60) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(bus.done), 32'h1);
   endtask

   task automatic send(input logic id, input logic [7:0] d);
      int  n = 0;
      logic rdy;
      @(posedge clk);
      #1;
      exp_q.push_back({id, d});
      if (id) begin bus.req1_valid = 1'b1; bus.req1_data = d; end
      else    begin bus.req0_valid = 1'b1; bus.req0_data = d; end
      forever begin
         @(negedge clk);
         rdy = id ? bus.req1_ready : bus.req0_ready;
         if (rdy || n > 60) break;
         n++;
      end
      check("send_ready_seen", 32'(rdy), 32'h1);
      @(posedge clk);
      #1;
      if (id) bus.req1_valid = 1'b0;
      else    bus.req0_valid = 1'b0;
   endtask

   initial begin
      logic [8:0] seq1 [8];
      logic [7:0] pat;
      int acc, guard, bad, base;

      bus.req0_valid  = 1'b0; bus.req0_data = '0;
      bus.req1_valid  = 1'b0; bus.req1_data = '0;
      busf.req0_valid = 1'b0; busf.req0_data = '0;
      busf.req1_valid = 1'b0; busf.req1_data = '0;
      reset_n = 1'b0;
      #1;
      check("rst_async_out_port", 32'(bus.out_port), 32'h0);
      do_reset();

      // Single byte A5, phase-by-phase.
      seq1 = '{9'h0A5, 9'h0A5, 9'h1A5, 9'h1A5, 9'h1A5, 9'h1A5, 9'h0A5, 9'h0A5};
      @(posedge clk); #1;
      exp_q.push_back({1'b0, 8'hA5});
      bus.req0_valid = 1'b1; bus.req0_data = 8'hA5;
      @(negedge clk);
      check("t1_ready0", 32'(bus.req0_ready), 32'h1);
      check("t1_ready1", 32'(bus.req1_ready), 32'h0);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check($sformatf("t1_out_%0d", i), 32'(bus.out_port), 32'(seq1[i]));
         check($sformatf("t1_busy_%0d", i), 32'(bus.busy), 32'h1);
         check($sformatf("t1_done_%0d", i), 32'(bus.done), 32'h0);
      end
      @(negedge clk);
      check("t1_done", 32'(bus.done), 32'h1);
      check("t1_busy_fall", 32'(bus.busy), 32'h0);
      @(negedge clk);
      check("t1_done_one_cycle", 32'(bus.done), 32'h0);
      check("t1_data_retained", 32'(bus.out_port), 32'h0A5);

      // Both requesters continuously valid: strict alternation from 0.
      do_reset();
      exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b1, 8'h22});
      exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b1, 8'h22});
      @(posedge clk); #1;
      bus.req0_valid = 1'b1; bus.req0_data = 8'h11;
      bus.req1_valid = 1'b1; bus.req1_data = 8'h22;
      acc = 0; guard = 0;
      while (acc < 4 && guard < 100) begin
         @(negedge clk);
         guard++;
         if (bus.req0_ready || bus.req1_ready) begin
            check("t2_grant_order", 32'(bus.req1_ready), 32'(acc % 2));
            check("t2_single_ready", 32'(bus.req0_ready ^ bus.req1_ready), 32'h1);
            acc++;
         end
      end
      check("t2_accepts", acc, 32'd4);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      wait_done("t2_done");
      check("t2_rise_count", rise_cyc.size(), 32'd4);
      if (rise_cyc.size() == 4) begin
         for (int i = 1; i < 4; i++)
            check($sformatf("t2_period_%0d", i), rise_cyc[i] - rise_cyc[i-1], 32'd9);
      end

      // req1 arrives during req0 SETUP: no ready until IDLE.
      @(posedge clk); #1;
      exp_q.push_back({1'b0, 8'h5C});
      bus.req0_valid = 1'b1; bus.req0_data = 8'h5C;
      guard = 0;
      do begin @(negedge clk); guard++; end while (!bus.req0_ready && guard < 60);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      exp_q.push_back({1'b1, 8'hC3});
      bus.req1_valid = 1'b1; bus.req1_data = 8'hC3;
      bad = 0; guard = 0;
      forever begin
         @(negedge clk);
         guard++;
         if (bus.req1_ready || guard > 60) break;
         if (!bus.busy) bad++;
      end
      check("t3_ready_only_in_idle", 32'(bus.busy), 32'h0);
      check("t3_waited_full_xfer", guard, 32'd9);
      check("t3_no_idle_without_ready", bad, 32'd0);
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
      @(negedge clk);
      check("t3_grant_id", 32'(bus.grant_id), 32'h1);
      wait_done("t3_done");

      // Reset during STROBE: immediate clear, no done, then normal transfer.
      @(posedge clk); #1;
      exp_q.push_back({1'b0, 8'h77});
      bus.req0_valid = 1'b1; bus.req0_data = 8'h77;
      guard = 0;
      do begin @(negedge clk); guard++; end while (!bus.req0_ready && guard < 60);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      guard = 0;
      do begin @(negedge clk); guard++; end while (!bus.out_port[STROBE_BIT] && guard < 60);
      check("t4_strobe_reached", 32'(bus.out_port[STROBE_BIT]), 32'h1);
      @(negedge clk);
      base = done_cnt;
      #2;
      reset_n = 1'b0;
      #1;
      check("t4_async_out_port", 32'(bus.out_port), 32'h0);
      check("t4_async_busy", 32'(bus.busy), 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      check("t4_no_done_pulse", done_cnt - base, 32'd0);
      send(1'b0, 8'h3C);
      wait_done("t4_done");
      check("t4_data", 32'(bus.out_port), 32'h03C);

      // Minimum-timing instance: 1-cycle strobe, 4-cycle period.
      @(posedge clk); #1;
      busf.req0_valid = 1'b1; busf.req0_data = 8'h5A;
      guard = 0;
      do begin @(negedge clk); guard++; end while (!busf.out_port[STROBE_BIT] && guard < 20);
      for (int i = 0; i < 8; i++) begin
         pat[i] = busf.out_port[STROBE_BIT];
         if (i < 7) @(negedge clk);
      end
      check("t5_strobe_pattern", 32'(pat), 32'h11);
      check("t5_data", 32'(busf.out_port[7:0]), 32'h5A);
      @(posedge clk); #1;
      busf.req0_valid = 1'b0;

`ifdef PIO_SEQ_STATS_EN
      do_reset();
      for (int i = 0; i < 3; i++) begin send(1'b0, 8'(8'h40 + i)); wait_done("t6_done0"); end
      for (int i = 0; i < 2; i++) begin send(1'b1, 8'(8'h80 + i)); wait_done("t6_done1"); end
      @(negedge clk);
      check("t6_xfer_cnt0", 32'(bus.xfer_cnt0), 32'd3);
      check("t6_xfer_cnt1", 32'(bus.xfer_cnt1), 32'd2);
      force dut.stat_cnt0 = 16'hFFFE;
      @(negedge clk);
      release dut.stat_cnt0;
      for (int i = 0; i < 3; i++) begin send(1'b0, 8'hE0); wait_done("t6_done_sat"); end
      @(negedge clk);
      check("t6_saturate", 32'(bus.xfer_cnt0), 32'hFFFF);
      check("t6_cnt1_kept", 32'(bus.xfer_cnt1), 32'd2);
`endif

      repeat (3) @(negedge clk);
      check("sb_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/pio_strobe_sequencer.md
Name: pio_strobe_sequencer

Overview:
- Sequences the 9-bit parallel PIO output bus toward the external memory-editor target: out_port[7:0] carries the data byte, out_port[8] carries the write strobe.
- Shares the bus between two requesters (0 = Nios command path, 1 = hardware key/scan path) using round-robin arbitration.
- Generates programmable setup/strobe/hold timing so that software does not have to bit-bang the strobe through the PIO register.

Parameters:
- DATA_W, 8, data byte width; out_port width = DATA_W+1.
- SETUP_CYC, 2, cycles data is stable before strobe rises (≥1).
- STROBE_CYC, 4, cycles strobe is held high (≥1).
- HOLD_CYC, 2, cycles data is held after strobe falls (≥1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a byte to send.
- req0_data  in  DATA_W  requester 0 byte.
- req0_ready  out  1  requester 0 byte accepted this cycle.
- req1_valid  in  1  requester 1 has a byte to send.
- req1_data  in  DATA_W  requester 1 byte.
- req1_ready  out  1  requester 1 byte accepted this cycle.
- out_port  out  DATA_W+1  [8] strobe, [7:0] data, to the external bus.
- busy  out  1  transfer in progress (state != IDLE).
- grant_id  out  1  requester owning the current or most recent transfer.
- done  out  1  one-cycle pulse after each transfer completes.

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE, out_port=0, busy=0, grant_id=0, done=0, rr_last=1 (so requester 0 wins the first tie), counter=0.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- Arbitration in IDLE, combinational:
  - only reqN_valid asserted → grant N.
  - both asserted → grant the requester != rr_last.
  - none asserted → no grant.
- reqN_ready = (state==IDLE) && granted N. It is combinational from valid; the ready of the non-granted requester is 0.
- Transfer happens on the edge where valid&&ready. At that edge: data is latched, grant_id<=N, rr_last<=N, state<=SETUP, counter<=SETUP_CYC-1.
- Requesters must hold valid/data stable until ready. Dropping valid before ready is legal and causes no transfer.
- SETUP: out_port={0,data}. When counter==0 → STROBE with counter<=STROBE_CYC-1; otherwise decrement.
- STROBE: out_port={1,data}. When counter==0 → HOLD with counter<=HOLD_CYC-1.
- HOLD: out_port={0,data}. When counter==0 → IDLE, and done<=1 for exactly the first IDLE cycle.
- IDLE: out_port[8]=0; out_port[7:0] retains the last byte (it is not cleared).
- Output timing: out_port is registered, with no combinational path from req inputs.
- Latency: the strobe rises SETUP_CYC cycles after the accept edge. Each transfer occupies 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles including the mandatory IDLE arbitration cycle. With default parameters the minimum period is 9 cycles.
- Both requesters continuously valid → grants strictly alternate 0,1,0,1…
- A request that arrives while busy waits; it sees no ready until IDLE.
- Counter width = $clog2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC)+1).
- Reset asserted mid-transfer: strobe and data drop to 0 immediately, no done pulse, and the in-flight byte is lost (ready was already given).

Optional Feature:
- Macro: PIO_SEQ_STATS_EN.
- When defined:
  - Adds output ports xfer_cnt0 and xfer_cnt1, 16 bits each.
  - Each counter increments on a done pulse whose grant_id matches its requester.
  - Counters saturate at 16'hFFFF.
  - Both counters reset to 0.
- When undefined: the ports and counters are absent, and the behaviour is otherwise identical.

Decomposition:
- Shared package pio_seq_pkg holds:
  - state enum (IDLE=2'd0, SETUP=2'd1, STROBE=2'd2, HOLD=2'd3);
  - DATA_W default;
  - STROBE_BIT index (=DATA_W).
- One sub-module is natural: pio_rr_arb2, the 2-way round-robin arbiter (valid[1:0], rr_last → grant one-hot, grant_id). Its rr_last register stays in the parent.

Test Plan:
- Reset, then a single request with req0_data=8'hA5 held valid:
  - req0_ready pulses once;
  - out_port=9'h0A5 for 2 cycles, then 9'h1A5 for 4 cycles, then 9'h0A5 for 2 cycles;
  - done pulses for 1 cycle and busy falls;
  - out_port[7:0] stays A5 afterwards.
- Both valid continuously with data0=8'h11 and data1=8'h22:
  - grant order is 0,1,0,1;
  - strobe high phases carry 11,22,11,22;
  - successive strobe rising edges are 9 cycles apart.
- req1 raised during the SETUP phase of a req0 transfer: req1_ready stays 0 until the next IDLE, then is accepted; grant_id=1.
- reset_n asserted during the STROBE phase: out_port=0 immediately with no done pulse. After release, a new req0 with 8'h3C completes normally.
- Parameter override SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=1: strobe is high for exactly 1 cycle and the period is 4 cycles.
- With PIO_SEQ_STATS_EN: 3 transfers from req0 and 2 from req1 give xfer_cnt0=3 and xfer_cnt1=2. Preloading a counter to FFFE via force and running 3 transfers leaves it at FFFF.
